// File: rtl/laser_pkg.sv
// Shared types, constants and the coverage test for the two-circle search.
package laser_pkg;

    localparam int NUM_PTS   = 40;
    localparam int GRID      = 16;
    localparam int RADIUS_SQ = 16;

    typedef logic [3:0] coord_t;
    typedef logic [5:0] cnt_t;

    typedef struct packed {
        coord_t x;
        coord_t y;
    } point_t;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_SCAN1  = 2'd1,
        ST_SCAN2  = 2'd2,
        ST_FINISH = 2'd3
    } state_e;

    // Distance test. Any axis offset above 4 can never be inside radius^2 = 16,
    // so those are rejected early and the squared sum never exceeds 6 bits.
    function automatic logic in_radius(coord_t cx, coord_t cy, coord_t px, coord_t py);
        logic [4:0] dx;
        logic [4:0] dy;
        logic [4:0] ax;
        logic [4:0] ay;
        logic [5:0] sx;
        logic [5:0] sy;
        logic [5:0] dsq;
        dx  = {1'b0, cx} - {1'b0, px};
        dy  = {1'b0, cy} - {1'b0, py};
        ax  = dx[4] ? 5'(-dx) : dx;
        ay  = dy[4] ? 5'(-dy) : dy;
        sx  = {3'b000, ax[2:0]};
        sy  = {3'b000, ay[2:0]};
        dsq = sx * sx + sy * sy;
        return (ax <= 5'd4) && (ay <= 5'd4) && (dsq <= 6'(RADIUS_SQ));
    endfunction

endpackage

// File: rtl/laser_search_ctrl_if.sv
// Point input and result bus of the laser search controller.
interface laser_search_ctrl_if;
    import laser_pkg::*;

    coord_t X;
    coord_t Y;
    coord_t C1X;
    coord_t C1Y;
    coord_t C2X;
    coord_t C2Y;
    logic   DONE;

    modport master (output X, Y, input C1X, C1Y, C2X, C2Y, DONE);
    modport slave  (input X, Y, output C1X, C1Y, C2X, C2Y, DONE);

endinterface

// File: rtl/laser_cover_unit.sv
// Counts how many of a group of PPC points are covered by a candidate centre
// or by the fixed centre; registered, one cycle of latency.
module laser_cover_unit
    import laser_pkg::*;
#(
    parameter int PPC = 8
) (
    input  logic               CLK,
    input  logic               RST,
    input  point_t [PPC-1:0]   pts,
    input  coord_t             cand_x,
    input  coord_t             cand_y,
    input  coord_t             fix_x,
    input  coord_t             fix_y,
    input  logic               fix_valid,
    output cnt_t               part_cnt
);

    cnt_t cnt_nxt;

    // Union coverage count of this point group.
    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < PPC; i++) begin
            if (in_radius(cand_x, cand_y, pts[i].x, pts[i].y) ||
                (fix_valid && in_radius(fix_x, fix_y, pts[i].x, pts[i].y))) begin
                cnt_nxt = cnt_nxt + 6'd1;
            end
        end
    end

    // Partial count register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            part_cnt <= '0;
        end else begin
            part_cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/laser_search_ctrl.sv
// Two-circle coverage search sequencer: loads 40 points, alternately scans the
// grid for centre 1 and centre 2, keeps the best union coverage, pulses DONE.
//
//  state     | meaning
//  LOAD      | capturing one point per clock into the point store
//  SCAN1     | sweeping all 256 candidates for centre 1, centre 2 fixed
//  SCAN2     | sweeping all 256 candidates for centre 2, centre 1 fixed
//  FINISH    | one-cycle DONE, results valid
module laser_search_ctrl
    import laser_pkg::*;
#(
    parameter int PPC        = 8,
    parameter int MAX_ROUNDS = 8
) (
    input logic                CLK,
    input logic                RST,
    laser_search_ctrl_if.slave bus
);

    localparam int GRPS     = NUM_PTS / PPC;
    localparam int GW       = (GRPS > 1) ? $clog2(GRPS) : 1;
    localparam int NCAND    = GRID * GRID;
    localparam int CW       = $clog2(NCAND);
    localparam int SCAN_LEN = NCAND * GRPS + 2;
    localparam int TW       = $clog2(SCAN_LEN);

    localparam logic [1:0] S_LOAD   = ST_LOAD;
    localparam logic [1:0] S_SCAN1  = ST_SCAN1;
    localparam logic [1:0] S_SCAN2  = ST_SCAN2;
    localparam logic [1:0] S_FINISH = ST_FINISH;

    logic [1:0]       state;
    point_t           pts [NUM_PTS];
    cnt_t             pt_cnt;
    logic [3:0]       round;
    logic             c2_valid;
    coord_t           c1_x, c1_y, c2_x, c2_y;
    cnt_t             best;
    cnt_t             prev_total;
    cnt_t             acc;
    logic [TW-1:0]    scan_tmr;
    logic [GW-1:0]    pt_grp;
    logic [CW-1:0]    cand_idx;
    logic             res_v;
    logic             res_last;
    logic [CW-1:0]    res_idx;
    cnt_t             part_cnt;
    point_t [PPC-1:0] grp_pts;
    logic             scanning;
    logic             feed;
    logic             grp_last;
    logic             tmr_tc;
    cnt_t             cand_sum;
    coord_t           fix_x, fix_y;
    logic             fix_valid;

    // Scan timer runs down over the feed cycles plus one drain and one decide cycle.
    assign scanning  = (state == S_SCAN1) || (state == S_SCAN2);
    assign tmr_tc    = (scan_tmr == '0);
    assign feed      = scanning && (scan_tmr > TW'(1));
    assign grp_last  = (pt_grp == GW'(GRPS - 1));
    assign cand_sum  = acc + part_cnt;
    assign fix_x     = (state == S_SCAN1) ? c2_x : c1_x;
    assign fix_y     = (state == S_SCAN1) ? c2_y : c1_y;
    assign fix_valid = (state == S_SCAN2) || c2_valid;

    assign bus.C1X  = c1_x;
    assign bus.C1Y  = c1_y;
    assign bus.C2X  = c2_x;
    assign bus.C2Y  = c2_y;
    assign bus.DONE = (state == S_FINISH);

    // Point store write port; contents are don't-care until fully reloaded.
    always_ff @(posedge CLK) begin
        if (state == S_LOAD) begin
            pts[pt_cnt] <= {bus.X, bus.Y};
        end
    end

    // PPC-wide read of the current point group.
    always_comb begin
        for (int j = 0; j < PPC; j++) begin
            grp_pts[j] = pts[cnt_t'(int'(pt_grp) * PPC + j)];
        end
    end

    laser_cover_unit #(.PPC(PPC)) u_cover (
        .CLK       (CLK),
        .RST       (RST),
        .pts       (grp_pts),
        .cand_x    (cand_idx[3:0]),
        .cand_y    (cand_idx[7:4]),
        .fix_x     (fix_x),
        .fix_y     (fix_y),
        .fix_valid (fix_valid),
        .part_cnt  (part_cnt)
    );

    // Candidate/group counters, result pipeline and per-candidate accumulator.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pt_grp   <= '0;
            cand_idx <= '0;
            res_v    <= 1'b0;
            res_last <= 1'b0;
            res_idx  <= '0;
            acc      <= '0;
        end else begin
            res_v    <= feed;
            res_last <= feed && grp_last;
            res_idx  <= cand_idx;
            if (feed) begin
                if (grp_last) begin
                    pt_grp   <= '0;
                    cand_idx <= cand_idx + CW'(1);
                end else begin
                    pt_grp <= pt_grp + GW'(1);
                end
            end
            if (res_v) begin
                acc <= res_last ? '0 : cand_sum;
            end
        end
    end

    // Round FSM, best tracker and result centres.
    // best carries over from one scan to the next: it always equals the union
    // coverage of the current centres. Entering round-1 SCAN2 it holds C1 alone,
    // but candidate 0 is (0,0) = current C2, so the first result restores the
    // true union without moving C2.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= S_LOAD;
            pt_cnt     <= '0;
            round      <= '0;
            c2_valid   <= 1'b0;
            c1_x       <= '0;
            c1_y       <= '0;
            c2_x       <= '0;
            c2_y       <= '0;
            best       <= '0;
            prev_total <= '0;
            scan_tmr   <= '0;
        end else begin
            case (state)
                S_LOAD: begin
                    if (pt_cnt == cnt_t'(NUM_PTS - 1)) begin
                        pt_cnt     <= '0;
                        c1_x       <= '0;
                        c1_y       <= '0;
                        c2_x       <= '0;
                        c2_y       <= '0;
                        c2_valid   <= 1'b0;
                        round      <= 4'd1;
                        best       <= '0;
                        prev_total <= '0;
                        scan_tmr   <= TW'(SCAN_LEN - 1);
                        state      <= S_SCAN1;
                    end else begin
                        pt_cnt <= pt_cnt + 6'd1;
                    end
                end
                S_SCAN1, S_SCAN2: begin
                    if (res_v && res_last && (cand_sum > best)) begin
                        best <= cand_sum;
                        if (state == S_SCAN1) begin
                            {c1_y, c1_x} <= res_idx;
                        end else begin
                            {c2_y, c2_x} <= res_idx;
                        end
                    end
                    if (!tmr_tc) begin
                        scan_tmr <= scan_tmr - TW'(1);
                    end else begin
                        scan_tmr <= TW'(SCAN_LEN - 1);
                        if (state == S_SCAN1) begin
                            c2_valid <= 1'b1;
                            state    <= S_SCAN2;
                        end else if ((best > prev_total) && (round < 4'(MAX_ROUNDS))) begin
                            round      <= round + 4'd1;
                            prev_total <= best;
                            state      <= S_SCAN1;
                        end else begin
                            state <= S_FINISH;
                        end
                    end
                end
                S_FINISH: begin
                    state <= S_LOAD;
                end
                default: begin
                    state <= S_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_laser_search_ctrl.sv
// Scoreboard bench for laser_search_ctrl: a golden search model pushes the
// expected centres and DONE latency at load time; DONE pops and compares.
module tb_laser_search_ctrl;
    import laser_pkg::*;

    localparam int PPC        = 8;
    localparam int MAX_ROUNDS = 8;
    localparam int SCAN_CYC   = 256 * (NUM_PTS / PPC) + 2;
    localparam int LAT_MAX    = NUM_PTS + 2 * MAX_ROUNDS * SCAN_CYC + 8;

    typedef struct {
        int c1x;
        int c1y;
        int c2x;
        int c2y;
        int lat;
    } exp_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    laser_search_ctrl_if bus_i ();

    laser_search_ctrl #(.PPC(PPC), .MAX_ROUNDS(MAX_ROUNDS)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus_i)
    );

    always #5 CLK = ~CLK;

    int   n_chk  = 0;
    int   n_pass = 0;
    int   pat_x [NUM_PTS];
    int   pat_y [NUM_PTS];
    exp_t sb_q [$];

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    function automatic bit hit(int cx, int cy, int i);
        int dx = cx - pat_x[i];
        int dy = cy - pat_y[i];
        return (dx * dx + dy * dy) <= RADIUS_SQ;
    endfunction

    function automatic int union_cnt(int ax, int ay, bit a_on, int bx, int by, bit b_on);
        int n = 0;
        for (int i = 0; i < NUM_PTS; i++)
            if ((a_on && hit(ax, ay, i)) || (b_on && hit(bx, by, i))) n++;
        return n;
    endfunction

    // Literal reading of the search: each scan starts from the union of the
    // current centres, strict improvement only, rounds until no gain.
    function automatic exp_t run_model();
        exp_t e;
        int c1x = 0, c1y = 0, c2x = 0, c2y = 0;
        int best, n, prev = 0, round = 1, scans = 0;
        bit c2v = 0;
        while (1) begin
            best = c2v ? union_cnt(c1x, c1y, 1, c2x, c2y, 1) : 0;
            for (int idx = 0; idx < 256; idx++) begin
                n = union_cnt(idx % 16, idx / 16, 1, c2x, c2y, c2v);
                if (n > best) begin best = n; c1x = idx % 16; c1y = idx / 16; end
            end
            scans++;
            c2v = 1;
            best = union_cnt(c1x, c1y, 1, c2x, c2y, 1);
            for (int idx = 0; idx < 256; idx++) begin
                n = union_cnt(c1x, c1y, 1, idx % 16, idx / 16, 1);
                if (n > best) begin best = n; c2x = idx % 16; c2y = idx / 16; end
            end
            scans++;
            if (best > prev && round < MAX_ROUNDS) begin
                round++;
                prev = best;
            end else begin
                break;
            end
        end
        e.c1x = c1x; e.c1y = c1y; e.c2x = c2x; e.c2y = c2y;
        e.lat = scans * SCAN_CYC + 1;
        return e;
    endfunction

    // Called at a negedge with the DUT ready to capture on the next posedge.
    task automatic load_pattern(input string tag);
        bit done_hit = 0;
        for (int i = 0; i < NUM_PTS; i++) begin
            bus_i.X = coord_t'(pat_x[i]);
            bus_i.Y = coord_t'(pat_y[i]);
            @(posedge CLK);
            @(negedge CLK);
            if (bus_i.DONE) done_hit = 1;
        end
        chk({tag, "_done_in_load"}, int'(done_hit), 0);
        sb_q.push_back(run_model());
    endtask

    // Entered at the first negedge after the last capture (latency 1).
    task automatic wait_done(input string tag);
        int   lat = 1;
        exp_t e;
        while (!bus_i.DONE && lat < LAT_MAX + 16) begin
            @(negedge CLK);
            lat++;
        end
        e = sb_q.pop_front();
        if (!bus_i.DONE) begin
            chk({tag, "_done_timeout"}, 0, 1);
            return;
        end
        chk({tag, "_c1x"}, int'(bus_i.C1X), e.c1x);
        chk({tag, "_c1y"}, int'(bus_i.C1Y), e.c1y);
        chk({tag, "_c2x"}, int'(bus_i.C2X), e.c2x);
        chk({tag, "_c2y"}, int'(bus_i.C2Y), e.c2y);
        chk({tag, "_latency"}, lat, e.lat);
        chk({tag, "_lat_bound"}, int'(lat <= LAT_MAX), 1);
        @(negedge CLK);
        chk({tag, "_done_pulse"}, int'(bus_i.DONE), 0);
    endtask

    task automatic set_p2();
        for (int i = 0; i < NUM_PTS; i++) begin pat_x[i] = 5; pat_y[i] = 5; end
    endtask

    task automatic set_p3();
        for (int i = 0; i < NUM_PTS; i++) begin
            pat_x[i] = (i < 20) ? 2 : 13;
            pat_y[i] = (i < 20) ? 2 : 13;
        end
    endtask

    task automatic set_random();
        int ax = $urandom_range(0, 15), ay = $urandom_range(0, 15);
        int bx = $urandom_range(0, 15), by = $urandom_range(0, 15);
        int s  = $urandom_range(1, 5);
        int vx, vy;
        for (int i = 0; i < NUM_PTS; i++) begin
            vx = ((i % 2) ? ax : bx) + $urandom_range(0, 2 * s) - s;
            vy = ((i % 2) ? ay : by) + $urandom_range(0, 2 * s) - s;
            pat_x[i] = (vx < 0) ? 0 : (vx > 15) ? 15 : vx;
            pat_y[i] = (vy < 0) ? 0 : (vy > 15) ? 15 : vy;
        end
    endtask

    // Async reset mid-search: outputs must clear before the next clock edge.
    task automatic abort_with_reset(input string tag);
        #2 RST = 1'b1;
        #1;
        chk({tag, "_rst_done"}, int'(bus_i.DONE), 0);
        chk({tag, "_rst_c1x"}, int'(bus_i.C1X), 0);
        chk({tag, "_rst_c1y"}, int'(bus_i.C1Y), 0);
        chk({tag, "_rst_c2x"}, int'(bus_i.C2X), 0);
        chk({tag, "_rst_c2y"}, int'(bus_i.C2Y), 0);
        void'(sb_q.pop_back());
        repeat (3) @(negedge CLK);
        RST = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus_i.X = '0;
        bus_i.Y = '0;
        repeat (3) @(negedge CLK);
        chk("init_done", int'(bus_i.DONE), 0);
        chk("init_c1x", int'(bus_i.C1X), 0);
        chk("init_c2y", int'(bus_i.C2Y), 0);
        RST = 1'b0;

        set_p2();
        load_pattern("p2");
        wait_done("p2");

        set_p3();
        load_pattern("p3_b2b");
        wait_done("p3_b2b");

        set_p2();
        load_pattern("p2_b2b");
        wait_done("p2_b2b");

        set_p2();
        load_pattern("p2_abort");
        repeat (1400) @(negedge CLK);
        chk("p2_scan2_c1x", int'(bus_i.C1X), 5);
        chk("p2_scan2_c1y", int'(bus_i.C1Y), 1);
        abort_with_reset("p2_abort");

        set_p3();
        load_pattern("p3_abort");
        repeat (1300) @(negedge CLK);
        abort_with_reset("p3_abort");
        load_pattern("p3_reload");
        wait_done("p3_reload");

        for (int k = 0; k < 4; k++) begin
            set_random();
            load_pattern($sformatf("rnd%0d", k));
            wait_done($sformatf("rnd%0d", k));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
